exec_unit_scheduler: RTL and testbench
======================================

// Module: exec_unit_scheduler
// PURPOSE
//   Shares the single ALU/FPU execution unit between two requesters (e.g. two issue slots).
//   Round-robin arbiter plus sequencing FSM: grants one request, holds the unit enabled for
//   the op's latency (ALU ops op[3]=0, FPU ops op[3]=1), captures the result, returns it
//   tagged with the requester id. One operation in flight at a time.
// PARAMETERS
//   WIDTH    32  operand/result width
//   ALU_LAT  1   cycles eu_en is held for an ALU op (>=1)
//   FPU_LAT  4   cycles eu_en is held for an FPU op (>=1)
// PORTS
//   clk         in   1      clock, all logic on rising edge
//   rst         in   1      synchronous reset, active-high
//   req0_valid  in   1      requester 0 has an op
//   req0_ready  out  1      requester 0 op accepted this cycle
//   req0_op     in   4      op code (bit3: 0=ALU, 1=FPU)
//   req0_a      in   WIDTH  operand 0
//   req0_b      in   WIDTH  operand 1
//   req1_*      --   --     same five signals for requester 1
//   eu_en       out  1      enable to execution unit
//   eu_op       out  4      op to execution unit
//   eu_a, eu_b  out  WIDTH  operands to execution unit
//   eu_res      in   WIDTH  execution unit result
//   resp_valid  out  1      result available
//   resp_ready  in   1      consumer takes result
//   resp_id     out  1      requester the result belongs to
//   resp_res    out  WIDTH  result
//   busy        out  1      FSM not in IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr=0, cnt=0, all outputs 0 (incl. resp_res, eu_*).
//   FSM states IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any reqN_valid: grant g = rr if req[rr]_valid else the other; reqg_ready=1 for
//     this one cycle only (combinational on valid+state); latch op/a/b/g;
//     cnt <= (op[3] ? FPU_LAT : ALU_LAT); -> EXEC. No valid: stay, ready both 0.
//   EXEC: eu_en=1, eu_op/eu_a/eu_b = latched values, stable for whole state; cnt decrements
//     each cycle; on the cycle cnt==1, resp_res <= eu_res, resp_id <= g, -> RESP.
//     eu_en is high exactly LAT consecutive cycles.
//   RESP: resp_valid=1, resp_res/resp_id stable; when resp_ready: rr <= ~g, -> IDLE.
//     Held indefinitely while resp_ready=0; no new grant while in EXEC or RESP.
//   Outside EXEC: eu_en=0 and eu_op/eu_a/eu_b driven 0 (unit result ORs ALU and FPU outputs).
//   Latency: accept at cycle t -> eu_en t+1..t+LAT -> resp_valid first at t+LAT+1.
//   Minimum issue spacing LAT+2 cycles (IDLE, EXEC*LAT, RESP).
//   Round-robin: after a completed response, the other requester has priority; a requester
//     alone is granted regardless of rr.
//   Reset mid-operation: op dropped, no response, next cycle IDLE with rr=0.
//   cnt width $clog2(max(ALU_LAT,FPU_LAT))+1; no wrap possible.
// TESTING
//   1. req0 op=4'h0 a=5 b=3 at t, model eu_res=8 -> eu_en t+1 only, resp_valid t+2, id=0, res=8.
//   2. req1 op=4'h8, FPU_LAT=4 -> eu_en high t+1..t+4, eu_op=8 stable, resp_valid t+5, id=1.
//   3. req0,req1 valid continuously, resp_ready=1 -> grants 0,1,0,1; resp_id alternates.
//   4. resp_ready=0 for 3 cycles in RESP -> resp_valid/res/id held, both req_ready=0, busy=1.
//   5. rst pulse during EXEC -> next cycle eu_en=0, busy=0, resp_valid never rises, rr=0.
//   6. only req1 valid with rr=0 -> req1_ready=1 same cycle, req0_ready=0.

Source files
------------

// File: rtl/exec_unit_scheduler.sv
// exec_unit_scheduler: shares one ALU/FPU execution unit between two requesters.
// Round-robin grant, holds eu_en for the op latency, returns the tagged result.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o   request handshake (ready only in IDLE)
//   reqN_op_i, reqN_a_i, reqN_b_i op code (bit3: 0=ALU, 1=FPU) and operands
//   eu_en_o, eu_op_o, eu_a_o, eu_b_o  execution unit drive (zero outside EXEC)
//   eu_res_i                      execution unit result
//   resp_valid_o / resp_ready_i   response handshake
//   resp_id_o, resp_res_o         requester tag and captured result
//   busy_o                        FSM not in IDLE
module exec_unit_scheduler #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1,
    parameter int FPU_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [3:0]       req0_op_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [3:0]       req1_op_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             eu_en_o,
    output logic [3:0]       eu_op_o,
    output logic [WIDTH-1:0] eu_a_o,
    output logic [WIDTH-1:0] eu_b_o,
    input  logic [WIDTH-1:0] eu_res_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_id_o,
    output logic [WIDTH-1:0] resp_res_o,
    output logic             busy_o
);

    localparam int MAX_LAT = (ALU_LAT > FPU_LAT) ? ALU_LAT : FPU_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    localparam logic [CW-1:0] ALU_CNT = CW'(ALU_LAT);
    localparam logic [CW-1:0] FPU_CNT = CW'(FPU_LAT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             rr_q;
    logic             g_q;
    logic [CW-1:0]    cnt_q;
    logic             eu_en_q;
    logic [3:0]       eu_op_q;
    logic [WIDTH-1:0] eu_a_q;
    logic [WIDTH-1:0] eu_b_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic [WIDTH-1:0] resp_res_q;
    logic             busy_q;

    logic             gnt0;
    logic             gnt1;
    logic             g_d;
    logic [3:0]       op_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;

    // rr names the preferred requester; a lone requester wins regardless.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rr_q) begin
            gnt1 = req1_valid_i;
            gnt0 = req0_valid_i & ~req1_valid_i;
        end else begin
            gnt0 = req0_valid_i;
            gnt1 = req1_valid_i & ~req0_valid_i;
        end
    end

    always_comb begin
        g_d  = gnt1;
        op_d = gnt1 ? req1_op_i : req0_op_i;
        a_d  = gnt1 ? req1_a_i  : req0_a_i;
        b_d  = gnt1 ? req1_b_i  : req0_b_i;
    end

    assign req0_ready_o = (state_q == IDLE) & gnt0;
    assign req1_ready_o = (state_q == IDLE) & gnt1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            g_q          <= 1'b0;
            cnt_q        <= '0;
            eu_en_q      <= 1'b0;
            eu_op_q      <= '0;
            eu_a_q       <= '0;
            eu_b_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_res_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        g_q     <= g_d;
                        eu_en_q <= 1'b1;
                        eu_op_q <= op_d;
                        eu_a_q  <= a_d;
                        eu_b_q  <= b_d;
                        cnt_q   <= op_d[3] ? FPU_CNT : ALU_CNT;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    // Last enabled cycle: the unit output is valid now.
                    if (cnt_q == CNT_ONE) begin
                        resp_res_q   <= eu_res_i;
                        resp_id_q    <= g_q;
                        resp_valid_q <= 1'b1;
                        eu_en_q      <= 1'b0;
                        eu_op_q      <= '0;
                        eu_a_q       <= '0;
                        eu_b_q       <= '0;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        rr_q         <= ~g_q;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign eu_en_o      = eu_en_q;
    assign eu_op_o      = eu_op_q;
    assign eu_a_o       = eu_a_q;
    assign eu_b_o       = eu_b_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_res_o   = resp_res_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_exec_unit_scheduler.sv
// tb_exec_unit_scheduler: directed vectors for exec_unit_scheduler.
// Execution unit model: ALU op adds, FPU op multiplies, zero when disabled.
module tb_exec_unit_scheduler;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         r0_v, r1_v, r0_rdy, r1_rdy;
    logic [3:0]   r0_op, r1_op;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic         eu_en;
    logic [3:0]   eu_op;
    logic [W-1:0] eu_a, eu_b, eu_res;
    logic         rsp_v, rsp_rdy, rsp_id, busy;
    logic [W-1:0] rsp_res;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign eu_res = eu_en ? (eu_op[3] ? eu_a * eu_b : eu_a + eu_b) : '0;

    exec_unit_scheduler #(.WIDTH(W), .ALU_LAT(1), .FPU_LAT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(r0_v), .req0_ready_o(r0_rdy), .req0_op_i(r0_op),
        .req0_a_i(r0_a), .req0_b_i(r0_b),
        .req1_valid_i(r1_v), .req1_ready_o(r1_rdy), .req1_op_i(r1_op),
        .req1_a_i(r1_a), .req1_b_i(r1_b),
        .eu_en_o(eu_en), .eu_op_o(eu_op), .eu_a_o(eu_a), .eu_b_o(eu_b),
        .eu_res_i(eu_res),
        .resp_valid_o(rsp_v), .resp_ready_i(rsp_rdy),
        .resp_id_o(rsp_id), .resp_res_o(rsp_res), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to the sampling point of the current cycle.
    task automatic samp;
        @(negedge clk);
    endtask

    // Advance to just after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int g_exp;
    logic seen;

    initial begin
        rst = 1'b1; rsp_rdy = 1'b1;
        r0_v = 0; r0_op = 0; r0_a = 0; r0_b = 0;
        r1_v = 0; r1_op = 0; r1_a = 0; r1_b = 0;
        step; step;
        samp;
        check("rst_busy", W'(busy), 0);
        check("rst_en", W'(eu_en), 0);
        check("rst_rv", W'(rsp_v), 0);
        check("rst_res", rsp_res, 0);
        check("rst_eua", eu_a, 0);
        step;
        rst = 1'b0;

        // rr=0 after reset: both valid -> requester 0 wins; withdraw before edge.
        r0_v = 1; r1_v = 1;
        samp;
        check("rr0_r0", W'(r0_rdy), 1);
        check("rr0_r1", W'(r1_rdy), 0);
        r0_v = 0; r1_v = 0;
        step;

        // Lone requester 1 with rr=0 is granted.
        r1_v = 1; r1_op = 4'h1; r1_a = 9; r1_b = 4;
        samp;
        check("lone_r1", W'(r1_rdy), 1);
        check("lone_r0", W'(r0_rdy), 0);
        step;
        r1_v = 0;
        samp;
        step;
        samp;
        check("lone_id", W'(rsp_id), 1);
        check("lone_res", rsp_res, 13);
        step;

        // ALU op from requester 0: 5+3.
        r0_v = 1; r0_op = 4'h0; r0_a = 5; r0_b = 3;
        samp;
        check("alu_rdy", W'(r0_rdy), 1);
        check("alu_idle", W'(busy), 0);
        step;
        r0_v = 0;
        samp;
        check("alu_en1", W'(eu_en), 1);
        check("alu_a", eu_a, 5);
        check("alu_b", eu_b, 3);
        check("alu_rv0", W'(rsp_v), 0);
        step;
        samp;
        check("alu_en2", W'(eu_en), 0);
        check("alu_op0", W'(eu_op), 0);
        check("alu_rv", W'(rsp_v), 1);
        check("alu_id", W'(rsp_id), 0);
        check("alu_res", rsp_res, 8);
        step;
        samp;
        check("alu_done", W'(busy), 0);
        check("alu_rvd", W'(rsp_v), 0);
        step;

        // FPU op from requester 1: 6*7, four enabled cycles.
        r1_v = 1; r1_op = 4'h8; r1_a = 6; r1_b = 7;
        samp;
        check("fpu_rdy", W'(r1_rdy), 1);
        step;
        r1_v = 0;
        for (int i = 0; i < 4; i++) begin
            samp;
            check($sformatf("fpu_en%0d", i), W'(eu_en), 1);
            check($sformatf("fpu_op%0d", i), W'(eu_op), 8);
            check($sformatf("fpu_rv%0d", i), W'(rsp_v), 0);
            step;
        end
        samp;
        check("fpu_enx", W'(eu_en), 0);
        check("fpu_rv", W'(rsp_v), 1);
        check("fpu_id", W'(rsp_id), 1);
        check("fpu_res", rsp_res, 42);
        step;

        // Both valid continuously: grants alternate 0,1,0,1 (rr=0 now).
        r0_v = 1; r0_op = 4'h0; r0_a = 10; r0_b = 1;
        r1_v = 1; r1_op = 4'h0; r1_a = 20; r1_b = 2;
        for (int i = 0; i < 4; i++) begin
            g_exp = i % 2;
            samp;
            check($sformatf("alt_r0_%0d", i), W'(r0_rdy), W'(g_exp == 0));
            check($sformatf("alt_r1_%0d", i), W'(r1_rdy), W'(g_exp == 1));
            step;
            samp;
            check($sformatf("alt_en%0d", i), W'(eu_en), 1);
            step;
            samp;
            check($sformatf("alt_id%0d", i), W'(rsp_id), W'(g_exp));
            check($sformatf("alt_res%0d", i), rsp_res, g_exp ? 22 : 11);
            step;
        end
        r0_v = 0; r1_v = 0;

        // Response back-pressure: hold for three cycles.
        r0_v = 1; r0_op = 4'h0; r0_a = 1; r0_b = 1;
        rsp_rdy = 0;
        samp;
        check("bp_rdy", W'(r0_rdy), 1);
        step;
        r1_v = 1;
        samp;
        step;
        for (int i = 0; i < 3; i++) begin
            samp;
            check($sformatf("bp_rv%0d", i), W'(rsp_v), 1);
            check($sformatf("bp_res%0d", i), rsp_res, 2);
            check($sformatf("bp_id%0d", i), W'(rsp_id), 0);
            check($sformatf("bp_r0_%0d", i), W'(r0_rdy), 0);
            check($sformatf("bp_r1_%0d", i), W'(r1_rdy), 0);
            check($sformatf("bp_busy%0d", i), W'(busy), 1);
            step;
        end
        rsp_rdy = 1;
        r0_v = 0; r1_v = 0;
        samp;
        step;
        samp;
        check("bp_idle", W'(busy), 0);
        step;

        // rr=1 now; lone requester 0 FPU op, reset in the middle of EXEC.
        r0_v = 1; r0_op = 4'h8; r0_a = 3; r0_b = 3;
        samp;
        check("rs_rdy", W'(r0_rdy), 1);
        step;
        r0_v = 0;
        samp;
        step;
        rst = 1;
        samp;
        step;
        rst = 0;
        samp;
        check("rs_en", W'(eu_en), 0);
        check("rs_busy", W'(busy), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            samp;
            if (rsp_v) seen = 1;
            step;
        end
        check("rs_norsp", W'(seen), 0);

        // rr back to 0: both valid -> requester 0 preferred.
        r0_v = 1; r1_v = 1;
        samp;
        check("rs_rr_r0", W'(r0_rdy), 1);
        check("rs_rr_r1", W'(r1_rdy), 0);
        r0_v = 0; r1_v = 0;
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
